// File: rtl/jerky_arb_pkg.sv
// jerky_arb_pkg: shared types for the jerky slot arbiter.
//   state_t : arbiter FSM states (idle/arbitrating, grant held)
//   phase_t : which slot class is up next (home requester 0, rotating pool)
package jerky_arb_pkg;

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;
   typedef enum logic {PH_HOME, PH_ROT}   phase_t;

endpackage

// File: rtl/jerky_slot_arbiter_rr_pick.sv
// rr_pick: combinational wrapping priority search over requesters 1..N-1.
//   req   in  [N-1:1]  rotating-pool request bits (requester 0 excluded)
//   ptr   in  IW       last rotating grantee; search starts at ptr+1
//   found out 1        some pool requester is asserting
//   idx   out IW       first asserting requester after ptr, wrapping N-1 -> 1
module rr_pick #(
   parameter int N = 8
) (
   input  logic [N-1:1]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   always_comb begin
      int c;
      c     = 1;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k < N; k++) begin
         // Map offset k onto the pool 1..N-1 so index 0 is never visited.
         c = ((int'(ptr) - 1 + k) % (N - 1)) + 1;
         if (!found && req[c]) begin
            found = 1'b1;
            idx   = IW'(c);
         end
      end
   end

endmodule

// File: rtl/jerky_slot_arbiter.sv
// jerky_slot_arbiter: shares one resource among N requesters. Slots alternate
// between the home requester 0 and a round-robin rotating pool 1..N-1. A grant
// is registered, one-hot, and held until the resource pulses done.
//   clk    in  1   rising-edge clock
//   rst_b  in  1   asynchronous active-low reset
//   req    in  N   request vector
//   done   in  1   resource finished current transaction (ignored when idle)
//   gnt    out N   one-hot grant, zero when idle
//   gnt_id out IW  index of granted requester, zero when idle
// Build option: JERKY_ARB_SKIP_EN defined -> work-conserving (an empty slot
// is handed to the other phase's candidate); undefined -> strict TDM (an
// empty slot is burned and the phase still advances).
module jerky_slot_arbiter
   import jerky_arb_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic [N-1:0]         req,
   input  logic                 done,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id
);

   localparam int IW = $clog2(N);

   state_t          state, state_n;
   phase_t          phase, phase_n;
   logic [IW-1:0]   ptr, ptr_n;
   logic [N-1:0]    gnt_n;
   logic [IW-1:0]   gnt_id_n;

   logic            rot_found;
   logic [IW-1:0]   rot_idx;
   logic            take_home, take_rot;
   phase_t          phase_flip;

   rr_pick #(.N(N)) u_pick (
      .req   (req[N-1:1]),
      .ptr   (ptr),
      .found (rot_found),
      .idx   (rot_idx)
   );

   assign phase_flip = (phase == PH_HOME) ? PH_ROT : PH_HOME;

`ifdef JERKY_ARB_SKIP_EN
   // Current phase wins if it has a candidate, otherwise the other phase.
   assign take_home = req[0] && (phase == PH_HOME || !rot_found);
   assign take_rot  = rot_found && (phase == PH_ROT || !req[0]);
`else
   assign take_home = req[0] && (phase == PH_HOME);
   assign take_rot  = rot_found && (phase == PH_ROT);
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state  <= ST_IDLE;
         phase  <= PH_HOME;
         ptr    <= IW'(N - 1);
         gnt    <= '0;
         gnt_id <= '0;
      end else begin
         state  <= state_n;
         phase  <= phase_n;
         ptr    <= ptr_n;
         gnt    <= gnt_n;
         gnt_id <= gnt_id_n;
      end
   end

   always_comb begin
      state_n  = state;
      phase_n  = phase;
      ptr_n    = ptr;
      gnt_n    = gnt;
      gnt_id_n = gnt_id;
      case (state)
         ST_IDLE: begin
`ifdef JERKY_ARB_SKIP_EN
            // Next phase is opposite the granted class; hold if nothing won.
            if (take_home)     phase_n = PH_ROT;
            else if (take_rot) phase_n = PH_HOME;
`else
            // Every idle cycle consumes a slot, granted or not.
            phase_n = phase_flip;
`endif
            if (take_home) begin
               gnt_n    = N'(1);
               gnt_id_n = '0;
               state_n  = ST_GRANT;
            end else if (take_rot) begin
               gnt_n    = N'(1) << rot_idx;
               gnt_id_n = rot_idx;
               ptr_n    = rot_idx;
               state_n  = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (done) begin
               gnt_n    = '0;
               gnt_id_n = '0;
               state_n  = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_jerky_slot_arbiter.sv
module tb_jerky_slot_arbiter;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_b = 1'b0;
   logic [N-1:0] req = '0;
   logic         done = 1'b0;
   logic [N-1:0] gnt;
   logic [2:0]   gnt_id;

   int n_checks = 0;
   int n_err    = 0;

   // reference model state: slot-level view of the arbiter
   bit m_busy;
   int m_gid;
   bit m_home_next;
   int m_last_rot;

   int gid_q[$];
   int gap_q[$];

   jerky_slot_arbiter #(.N(N)) dut (
      .clk    (clk),
      .rst_b  (rst_b),
      .req    (req),
      .done   (done),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy      = 0;
      m_gid       = 0;
      m_home_next = 1;
      m_last_rot  = N - 1;
   endtask

   // One arbitration slot decided from the rules: home = requester 0,
   // rotating = first requester after the last rotating winner in 1..N-1.
   task automatic model_edge();
      bit home_ok;
      int rot;
      if (!rst_b) begin
         model_reset();
         return;
      end
      if (m_busy) begin
         if (done) begin
            m_busy = 0;
            m_gid  = 0;
         end
         return;
      end
      home_ok = req[0];
      rot = -1;
      for (int k = 1; k < N; k++) begin
         int i;
         i = ((m_last_rot - 1 + k) % (N - 1)) + 1;
         if (rot < 0 && req[i]) rot = i;
      end
`ifdef JERKY_ARB_SKIP_EN
      if (home_ok && (m_home_next || rot < 0)) begin
         m_busy = 1; m_gid = 0; m_home_next = 0;
      end else if (rot >= 0) begin
         m_busy = 1; m_gid = rot; m_last_rot = rot; m_home_next = 1;
      end
`else
      if (m_home_next && home_ok) begin
         m_busy = 1; m_gid = 0;
      end else if (!m_home_next && rot >= 0) begin
         m_busy = 1; m_gid = rot; m_last_rot = rot;
      end
      m_home_next = !m_home_next;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst_b = 0;
      req   = '0;
      done  = 0;
      step();
      step();
      rst_b = 1;
   endtask

   // Pulses done in the first cycle of each grant; records grantees and the
   // number of all-zero cycles preceding each grant.
   task automatic collect(input int n, input int budget);
      int z = 0;
      bit seen = 0;
      int cyc = 0;
      gid_q.delete();
      gap_q.delete();
      done = 0;
      while (gid_q.size() < n && cyc < budget) begin
         step();
         cyc++;
         if (gnt != '0) begin
            if (!seen) begin
               gid_q.push_back(int'(gnt_id));
               gap_q.push_back(z);
               z = 0;
               seen = 1;
            end
            done = 1;
         end else begin
            done = 0;
            seen = 0;
            z++;
         end
      end
      done = 0;
   endtask

   task automatic test_reset();
      rst_b = 0;
      for (int c = 0; c < 4; c++) begin
         req = N'($urandom);
         step();
         n_checks++;
         if (gnt !== '0 || gnt_id !== '0) begin
            n_err++;
            $display("FAIL reset_hold gnt=%h id=%0d want 00/0", gnt, gnt_id);
         end
      end
      rst_b = 1;
      req   = 8'h01;
      step();
      n_checks++;
      if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
         n_err++;
         $display("FAIL reset_first_grant gnt=%h id=%0d want 01/0", gnt, gnt_id);
      end
   endtask

   task automatic test_all_req();
      do_reset();
      req = 8'hFF;
      collect(16, 100);
      n_checks++;
      if (gid_q.size() != 16) begin
         n_err++;
         $display("FAIL all_req_count got %0d want 16", gid_q.size());
      end
      for (int i = 0; i < gid_q.size(); i++) begin
         int exp_id;
         exp_id = (i % 2 == 0) ? 0 : ((i / 2) % 7) + 1;
         n_checks++;
         if (gid_q[i] != exp_id) begin
            n_err++;
            $display("FAIL all_req_seq[%0d] got %0d want %0d", i, gid_q[i], exp_id);
         end
         if (i > 0) begin
            n_checks++;
            if (gap_q[i] != 1) begin
               n_err++;
               $display("FAIL all_req_gap[%0d] got %0d want 1", i, gap_q[i]);
            end
         end
      end
   endtask

   task automatic test_sparse();
      int exp_gap;
`ifdef JERKY_ARB_SKIP_EN
      exp_gap = 1;
`else
      exp_gap = 2;
`endif
      do_reset();
      req = 8'h24;
      collect(5, 80);
      n_checks++;
      if (gid_q.size() != 5) begin
         n_err++;
         $display("FAIL sparse_count got %0d want 5", gid_q.size());
      end
      for (int i = 0; i < gid_q.size(); i++) begin
         int exp_id;
         exp_id = (i % 2 == 0) ? 2 : 5;
         n_checks++;
         if (gid_q[i] != exp_id) begin
            n_err++;
            $display("FAIL sparse_seq[%0d] got %0d want %0d", i, gid_q[i], exp_id);
         end
         if (i > 0) begin
            n_checks++;
            if (gap_q[i] != exp_gap) begin
               n_err++;
               $display("FAIL sparse_gap[%0d] got %0d want %0d", i, gap_q[i], exp_gap);
            end
         end
      end
   endtask

   task automatic test_hold();
      int cyc = 0;
      do_reset();
      req = 8'h08;
      while (gnt == '0 && cyc < 10) begin
         step();
         cyc++;
      end
      n_checks++;
      if (gnt !== 8'h08 || gnt_id !== 3'd3) begin
         n_err++;
         $display("FAIL hold_first gnt=%h id=%0d want 08/3", gnt, gnt_id);
      end
      req = 8'h09;
      for (int c = 0; c < 10; c++) begin
         step();
         n_checks++;
         if (gnt !== 8'h08 || gnt_id !== 3'd3) begin
            n_err++;
            $display("FAIL hold_stable[%0d] gnt=%h want 08", c, gnt);
         end
         if (c == 4) req = 8'h01;
      end
      done = 1;
      step();
      done = 0;
      n_checks++;
      if (gnt !== '0) begin
         n_err++;
         $display("FAIL hold_release gnt=%h want 00", gnt);
      end
      step();
      n_checks++;
      if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
         n_err++;
         $display("FAIL hold_next gnt=%h id=%0d want 01/0", gnt, gnt_id);
      end
   endtask

   task automatic test_async_reset();
      int cyc = 0;
      do_reset();
      req = 8'hFF;
      step();
      n_checks++;
      if (gnt !== 8'h01) begin
         n_err++;
         $display("FAIL async_pre gnt=%h want 01", gnt);
      end
      #3;
      rst_b = 0;
      #1;
      model_reset();
      n_checks++;
      if (gnt !== '0 || gnt_id !== '0) begin
         n_err++;
         $display("FAIL async_drop gnt=%h id=%0d want 00/0", gnt, gnt_id);
      end
      step();
      rst_b = 1;
      req   = 8'hFE;
      while (gnt == '0 && cyc < 6) begin
         step();
         cyc++;
      end
      n_checks++;
      if (gnt !== 8'h02 || gnt_id !== 3'd1) begin
         n_err++;
         $display("FAIL async_restart gnt=%h id=%0d want 02/1", gnt, gnt_id);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic [N-1:0] exp_gnt;
         case ($urandom % 4)
            0: req = '0;
            1: req = N'($urandom) & N'($urandom) & N'($urandom);
            2: req = N'($urandom) & 8'hFE;
            default: req = N'($urandom);
         endcase
         done = ($urandom % 3 == 0);
         step();
         exp_gnt = m_busy ? (N'(1) << m_gid) : '0;
         n_checks++;
         if (gnt !== exp_gnt || int'(gnt_id) != m_gid) begin
            n_err++;
            $display("FAIL random[%0d] gnt=%h id=%0d want %h/%0d", c, gnt, gnt_id, exp_gnt, m_gid);
         end
      end
      done = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_all_req();
      test_sparse();
      test_hold();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
